// File: rtl/snpu_pkg.sv
// Shared constants, command encodings and FSM states for the SNPU policy deck.
package snpu_pkg;

    localparam int unsigned N_CARDS   = 17;
    localparam logic [16:0] INIT_DECK = 17'h0003F;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        OP_RESET_DECK = 3'd0,
        OP_SHUFFLE    = 3'd1,
        OP_DRAW       = 3'd2,
        OP_SHOW       = 3'd3,
        OP_DISCARD    = 3'd4,
        OP_PLAY       = 3'd5
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_SWAP,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/snpu_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and single-step advance.
module snpu_lfsr16
    import snpu_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [15:0] i_seed,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/policy_deck_ctrl.sv
// Policy deck sequencer: owns the 17-card deck vector and its stack/discard/board
// split, and executes multi-cycle shuffle/draw/show/discard/play commands.
module policy_deck_ctrl #(
    parameter int unsigned N_CARDS        = 17,
    parameter logic [16:0] INIT_DECK      = 17'h0003F,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned SHUFFLE_PASSES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_idx,
    input  logic [15:0] seed_in,
    output logic        done,
    output logic        err,
    output logic        card_out,
    output logic [1:0]  hand_n,
    output logic [4:0]  n_stack,
    output logic [4:0]  n_discard,
    output logic [3:0]  board_zeros,
    output logic [3:0]  board_ones
);
    import snpu_pkg::*;

    logic [16:0] r_deck;
    logic [4:0]  r_s, r_d, r_i, r_j, r_pos, r_cnt;
    logic [1:0]  r_hand;
    logic [3:0]  r_zeros, r_ones;
    logic [7:0]  r_pass;
    logic        r_card_out, r_done, r_err, r_is_play, r_play_val;
    state_t      r_state;

    logic [15:0] w_lfsr, w_lfsr_seed;
    logic        w_lfsr_load, w_lfsr_step, w_unused_lfsr;
    logic [4:0]  w_hand_pos, w_sum, w_shift, w_pos_up, w_j_raw, w_j;
    logic        w_j_ok, w_bad_idx;
    logic        w_commit, w_commit_play, w_commit_val;

    assign w_hand_pos    = r_s - 5'd1 - {3'b000, cmd_idx};
    assign w_sum         = r_s + r_d;
    assign w_bad_idx     = (cmd_idx >= r_hand);
    assign w_shift       = {3'b000, cmd_idx} + ((cmd_op == OP_PLAY) ? r_d : 5'd0);
    assign w_pos_up      = r_pos + 5'd1;
    assign w_lfsr_load   = (r_state == ST_IDLE) && cmd_valid && (cmd_op == OP_RESET_DECK);
    assign w_lfsr_step   = (r_state == ST_PICK);
    assign w_lfsr_seed   = (seed_in == '0) ? LFSR_SEED : seed_in;
    assign w_unused_lfsr = ^w_lfsr[15:5];

    snpu_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_lfsr_load),
        .i_step  (w_lfsr_step),
        .i_seed  (w_lfsr_seed),
        .o_value (w_lfsr)
    );

    // Fold an out-of-range draw once into [0, i]; a second miss retries next cycle.
    always_comb begin
        w_j_raw = w_lfsr[4:0];
        w_j     = w_j_raw;
        if (w_j_raw > r_i) begin
            w_j = w_j_raw - (r_i + 5'd1);
        end
        w_j_ok = (w_j <= r_i);
    end

    // Discard/play resolve either at acceptance (no shifting needed) or on the last SHIFT cycle.
    always_comb begin
        w_commit      = 1'b0;
        w_commit_play = 1'b0;
        w_commit_val  = 1'b0;
        if ((r_state == ST_IDLE) && cmd_valid && ((cmd_op == OP_DISCARD) || (cmd_op == OP_PLAY))
            && !w_bad_idx && (w_shift == '0)) begin
            w_commit      = 1'b1;
            w_commit_play = (cmd_op == OP_PLAY);
            w_commit_val  = r_deck[w_hand_pos];
        end else if ((r_state == ST_SHIFT) && (r_cnt == 5'd1)) begin
            w_commit      = 1'b1;
            w_commit_play = r_is_play;
            w_commit_val  = r_play_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deck     <= INIT_DECK;
            r_s        <= 5'(N_CARDS);
            r_d        <= '0;
            r_hand     <= '0;
            r_zeros    <= '0;
            r_ones     <= '0;
            r_card_out <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_pos      <= '0;
            r_cnt      <= '0;
            r_pass     <= '0;
            r_is_play  <= 1'b0;
            r_play_val <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_RESET_DECK: begin
                                r_deck     <= INIT_DECK;
                                r_s        <= 5'(N_CARDS);
                                r_d        <= '0;
                                r_hand     <= '0;
                                r_zeros    <= '0;
                                r_ones     <= '0;
                                r_card_out <= 1'b0;
                                r_done     <= 1'b1;
                            end
                            OP_SHUFFLE: begin
                                if (r_hand != '0) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_s    <= w_sum;
                                    r_d    <= '0;
                                    r_pass <= '0;
                                    r_i    <= w_sum - 5'd1;
                                    r_state <= (w_sum <= 5'd1) ? ST_FINISH : ST_PICK;
                                end
                            end
                            OP_DRAW: begin
                                if ((r_hand != '0) || (r_s < 5'd3)) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_hand <= 2'd3;
                                    r_done <= 1'b1;
                                end
                            end
                            OP_SHOW: begin
                                if (w_bad_idx) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_card_out <= r_deck[w_hand_pos];
                                    r_done     <= 1'b1;
                                end
                            end
                            OP_DISCARD, OP_PLAY: begin
                                if (w_bad_idx) begin
                                    r_err <= 1'b1;
                                end else if (w_shift != '0) begin
                                    r_is_play  <= (cmd_op == OP_PLAY);
                                    r_play_val <= r_deck[w_hand_pos];
                                    r_pos      <= w_hand_pos;
                                    r_cnt      <= w_shift;
                                    r_state    <= ST_SHIFT;
                                end
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                ST_PICK: begin
                    if (w_j_ok) begin
                        r_j     <= w_j;
                        r_state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    r_deck[r_i] <= r_deck[r_j];
                    r_deck[r_j] <= r_deck[r_i];
                    r_i         <= r_i - 5'd1;
                    r_state     <= ST_PICK;
                    if (r_i == 5'd1) begin
                        if (r_pass == 8'(SHUFFLE_PASSES - 1)) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_pass <= r_pass + 8'd1;
                            r_i    <= r_s - 5'd1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_deck[r_pos]    <= r_deck[w_pos_up];
                    r_deck[w_pos_up] <= r_deck[r_pos];
                    r_pos            <= w_pos_up;
                    r_cnt            <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_commit) begin
                r_s    <= r_s - 5'd1;
                r_hand <= r_hand - 2'd1;
                r_done <= 1'b1;
                if (w_commit_play) begin
                    if (w_commit_val) begin
                        r_ones <= r_ones + 4'd1;
                    end else begin
                        r_zeros <= r_zeros + 4'd1;
                    end
                end else begin
                    r_d <= r_d + 5'd1;
                end
            end
        end
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign card_out    = r_card_out;
    assign hand_n      = r_hand;
    assign n_stack     = r_s;
    assign n_discard   = r_d;
    assign board_zeros = r_zeros;
    assign board_ones  = r_ones;

endmodule

// File: tb/tb_policy_deck_ctrl.sv
// Scoreboard bench for policy_deck_ctrl: a list-based deck model predicts each
// command's outcome and latency; a monitor checks them when done/err pulses.
module tb_policy_deck_ctrl;

    localparam logic [16:0] INIT_DECK = 17'h0003F;
    localparam int unsigned SEED0     = 32'h0000ACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [1:0]  cmd_idx = '0;
    logic [15:0] seed_in = '0;
    logic        cmd_ready, done, err, card_out;
    logic [1:0]  hand_n;
    logic [4:0]  n_stack, n_discard;
    logic [3:0]  board_zeros, board_ones;

    policy_deck_ctrl #(
        .N_CARDS        (17),
        .INIT_DECK      (INIT_DECK),
        .LFSR_SEED      (16'hACE1),
        .SHUFFLE_PASSES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_idx     (cmd_idx),
        .seed_in     (seed_in),
        .done        (done),
        .err         (err),
        .card_out    (card_out),
        .hand_n      (hand_n),
        .n_stack     (n_stack),
        .n_discard   (n_discard),
        .board_zeros (board_zeros),
        .board_ones  (board_ones)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit is_err;
        int lat;
        int acc;
        int s;
        int d;
        int hand;
        int z;
        int o;
        int card;
    } exp_t;

    exp_t q[$];

    // Reference deck as an ordered list: index 0 = bottom of stack.
    int          m_deck[$];
    int          m_s, m_d, m_hand, m_z, m_o, m_card;
    int unsigned m_lfsr;

    function automatic void chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic int unsigned lfsr_step(input int unsigned v);
        int unsigned n;
        n = v >> 1;
        if ((v & 1) != 0) n = n ^ 32'h0000B400;
        return n;
    endfunction

    task automatic model_reset_deck();
        logic [16:0] init_v;
        init_v = INIT_DECK;
        m_deck.delete();
        for (int i = 0; i < 17; i++) m_deck.push_back(int'(init_v[i]));
        m_s = 17; m_d = 0; m_hand = 0; m_z = 0; m_o = 0; m_card = 0;
    endtask

    task automatic model_apply(input int op, input int idx, input int unsigned seed, output exp_t e);
        int p, v, picks, swaps, i, j, tmp;
        e.is_err = 1'b0;
        e.lat = 1;
        case (op)
            0: begin
                model_reset_deck();
                m_lfsr = (seed == 0) ? SEED0 : seed;
            end
            1: begin
                if (m_hand != 0) e.is_err = 1'b1;
                else begin
                    m_s = m_s + m_d;
                    m_d = 0;
                    picks = 0;
                    swaps = 0;
                    i = m_s - 1;
                    while (i > 0) begin
                        j = int'(m_lfsr & 31);
                        m_lfsr = lfsr_step(m_lfsr);
                        picks++;
                        if (j > i) j = j - (i + 1);
                        if (j <= i) begin
                            tmp = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = tmp;
                            swaps++;
                            i--;
                        end
                    end
                    e.lat = picks + swaps + 2;
                end
            end
            2: begin
                if (m_hand != 0 || m_s < 3) e.is_err = 1'b1;
                else m_hand = 3;
            end
            3: begin
                if (idx >= m_hand) e.is_err = 1'b1;
                else m_card = m_deck[m_s - 1 - idx];
            end
            4: begin
                if (idx >= m_hand) e.is_err = 1'b1;
                else begin
                    p = m_s - 1 - idx;
                    v = m_deck[p];
                    m_deck.delete(p);
                    m_deck.insert(m_s - 1, v);
                    m_s--; m_d++; m_hand--;
                    e.lat = idx + 1;
                end
            end
            5: begin
                if (idx >= m_hand) e.is_err = 1'b1;
                else begin
                    p = m_s - 1 - idx;
                    v = m_deck[p];
                    e.lat = idx + m_d + 1;
                    m_deck.delete(p);
                    m_deck.insert(m_s + m_d - 1, v);
                    m_s--; m_hand--;
                    if (v != 0) m_o++; else m_z++;
                end
            end
            default: e.is_err = 1'b1;
        endcase
        e.s = m_s; e.d = m_d; e.hand = m_hand; e.z = m_z; e.o = m_o; e.card = m_card;
    endtask

    task automatic issue(input int op, input int idx, input int unsigned seed, input bit wait_done);
        exp_t e;
        int n;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout cmd_ready=%0b required=1", cmd_ready);
            return;
        end
        model_apply(op, idx, seed, e);
        e.acc = cyc + 1;
        q.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_idx   = 2'(idx);
        seed_in   = 16'(seed);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (wait_done) begin
            n = 0;
            while (q.size() != 0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL done_timeout pending=%0d required=0", q.size());
                q.delete();
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_n_stack"}, int'(n_stack), m_s);
        chk({tag, "_n_discard"}, int'(n_discard), m_d);
        chk({tag, "_hand_n"}, int'(hand_n), m_hand);
        chk({tag, "_board_zeros"}, int'(board_zeros), m_z);
        chk({tag, "_board_ones"}, int'(board_ones), m_o);
        chk({tag, "_card_out"}, int'(card_out), m_card);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    // Monitor: pops the oldest expectation on each done/err pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done || err) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse done=%0b err=%0b required=none", done, err);
                end else begin
                    e = q.pop_front();
                    chk("err_pulse", int'(err), int'(e.is_err));
                    chk("done_pulse", int'(done), int'(!e.is_err));
                    chk("latency", cyc - e.acc + 1, e.lat);
                    chk("n_stack", int'(n_stack), e.s);
                    chk("n_discard", int'(n_discard), e.d);
                    chk("hand_n", int'(hand_n), e.hand);
                    chk("board_zeros", int'(board_zeros), e.z);
                    chk("board_ones", int'(board_ones), e.o);
                    chk("card_out", int'(card_out), e.card);
                    chk("ready_at_end", int'(cmd_ready), 1);
                end
            end else if (q.size() != 0 && cyc >= q[0].acc) begin
                chk("busy_ready", int'(cmd_ready), 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op, r;
        int unsigned sd;
        model_reset_deck();
        m_lfsr = SEED0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("reset");

        issue(2, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) issue(3, k, 0, 1'b1);

        for (int rep = 0; rep < 2; rep++) begin
            issue(0, 0, 32'h1234, 1'b1);
            issue(1, 0, 0, 1'b1);
            issue(2, 0, 0, 1'b1);
            for (int k = 0; k < 3; k++) issue(3, k, 0, 1'b1);
        end

        issue(0, 0, 0, 1'b1);
        issue(2, 0, 0, 1'b1);
        issue(2, 0, 0, 1'b1);
        issue(4, 2, 0, 1'b1);
        issue(3, 3, 0, 1'b1);

        issue(0, 0, 32'h00BEEF, 1'b1);
        issue(2, 0, 0, 1'b1);
        issue(4, 0, 0, 1'b1);
        issue(5, 1, 0, 1'b1);
        issue(1, 0, 0, 1'b1);
        issue(7, 0, 0, 1'b1);
        issue(6, 1, 0, 1'b1);
        issue(5, 0, 0, 1'b1);
        issue(1, 0, 0, 1'b1);
        issue(2, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) issue(3, k, 0, 1'b1);

        issue(0, 0, 32'h5A5A, 1'b1);
        issue(1, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete();
        model_reset_deck();
        m_lfsr = SEED0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("abort");
        issue(2, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) issue(3, k, 0, 1'b1);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) op = 0;
            else if (r <= 2) op = 1;
            else if (r <= 6) op = 2;
            else if (r <= 9) op = 3;
            else if (r <= 13) op = 4;
            else if (r <= 17) op = 5;
            else op = 6 + (r - 18);
            sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535);
            issue(op, int'($urandom_range(0, 3)), sd, 1'b1);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
